word_assembler: RTL
===================

// Module: word_assembler
// PURPOSE
//  Byte-serial to 32-bit word packer: the receive-side inverse of the word splitter.
//  Accepts one bit-reversed byte per handshake, MSB lane first.
//  Rebuilds the original 32-bit word and presents it on a valid/ready output port.
//  Sits between a byte-wide link/stream source and word-wide datapath logic.
// PARAMETERS
//  BIT_REV  1  1: each input byte is bit-reversed before placement (inverse of splitter); 0: placed as-is
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  reset      in   1   synchronous, active-high reset
//  clear      in   1   sync flush: drops partial word and any held word
//  in_valid   in   1   in_byte is valid this cycle
//  in_byte    in   8   serial byte; 1st byte -> lane 3, 4th -> lane 0
//  in_ready   out  1   assembler accepts in_byte this cycle
//  out_word   out  32  assembled word; stable while out_valid=1
//  out_valid  out  1   out_word holds a complete word
//  out_ready  in   1   consumer takes out_word this cycle
//  byte_cnt   out  2   bytes collected toward the current word (0..3)
// BEHAVIOUR
//  - Reset (reset=1 at edge): out_valid=0, out_word=0, byte_cnt=0, state=COLLECT; any partial data is lost.
//  - Byte accept: in_valid & in_ready at an edge.
//  - Word handoff: out_valid & out_ready at an edge.
//  - Lane mapping, k = byte_cnt at accept, with b' = BIT_REV ? rev8(in_byte) : in_byte:
//      word[31-8k -: 8] <= b'
//    rev8: b'[i] = in_byte[7-i]. With BIT_REV=1, word[31-j] = byte0[j], word[23-j] = byte1[j], etc.
//  - FSM states:
//    COLLECT: out_valid=0, in_ready=1. Accept -> byte_cnt+1.
//      On accepting the byte at byte_cnt=3: load out_word, byte_cnt wraps to 0, go to FULL.
//    FULL: out_valid=1.
//      in_ready = out_ready, giving 1 byte/cycle throughput with no bubble.
//      Handoff without accept -> COLLECT.
//      Handoff with accept -> stay COLLECT; the new byte is lane 3 of the next word and byte_cnt=1.
//  - Latency: 4th byte accepted at edge t -> out_valid=1 and out_word valid after edge t (same cycle visible).
//    No combinational path from in_byte to out_word.
//  - out_word register updates only on completion of a word; the partial accumulator is separate.
//    out_word holds its last value after handoff.
//  - Backpressure: in FULL with out_ready=0, in_ready=0; out_word/out_valid held indefinitely.
//  - clear=1: in_ready forced 0 (coincident byte dropped), byte_cnt=0, out_valid=0, state=COLLECT.
//    out_word is not zeroed.
//  - reset has priority over clear; clear has priority over accept/handoff.
//  - in_byte is ignored when in_valid=0 or in_ready=0; X on in_byte is then harmless.
// STRUCTURE
//  - Shared package:
//    - FSM state encoding (COLLECT=1'b0, FULL=1'b1).
//    - LANE_W=8, WORD_LANES=4.
//    - rev8 function, shared with the splitter test model.
//  - One sub-module: bit_reverse8 (combinational, 8-in/8-out), instantiated once on in_byte.
//    It is bypassed by generate when BIT_REV=0.
//  - Top holds: FSM, 2-bit lane counter, 24-bit partial accumulator, 32-bit out_word register.
// TESTING
//  - Basic, BIT_REV=1, out_ready=1: bytes 80,40,20,10 on consecutive cycles
//    -> out_valid one cycle after 4th accept, out_word=0x01020408.
//  - Round trip: feed 48,2C,6A,1E (the splitter output for 0x12345678) -> out_word=0x12345678.
//  - Streaming: 8 bytes back-to-back with in_valid=1 and out_ready=1
//    -> in_ready never 0; two words 1 apart by 4 cycles.
//  - Backpressure: complete a word with out_ready=0, keep in_valid=1 for 5 cycles
//    -> in_ready=0, out_word stable.
//    Then raise out_ready -> handoff and the next byte accepted in the same cycle, byte_cnt=1.
//  - Flush/reset: 2 bytes, then clear=1 together with in_valid=1 -> byte_cnt=0, out_valid=0.
//    Then bytes 80,40,20,10 -> 0x01020408.
//    Repeat with reset instead of clear -> same result, out_word=0 after reset.
//  - BIT_REV=0: bytes 12,34,56,78 -> out_word=0x12345678.

Source files
------------

// File: rtl/word_assembler_pkg.sv
// Shared definitions for the byte-to-word assembler and its test models.
//   state_t : assembler FSM encoding (COLLECT=0, FULL=1)
//   LANE_W, WORD_LANES, WORD_W : lane/word geometry
//   rev8()  : reverses the bit order of one lane byte
package word_assembler_pkg;

  localparam int LANE_W     = 8;
  localparam int WORD_LANES = 4;
  localparam int WORD_W     = LANE_W * WORD_LANES;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  // Bit i of the result is bit (LANE_W-1-i) of the input.
  function automatic logic [LANE_W-1:0] rev8(input logic [LANE_W-1:0] b);
    logic [LANE_W-1:0] r;
    for (int i = 0; i < LANE_W; i++) begin
      r[i] = b[LANE_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/word_assembler_bit_reverse8.sv
// Combinational bit reversal of one byte.
//   in_byte  : input byte
//   out_byte : in_byte with bit order reversed (out_byte[i] = in_byte[7-i])
module bit_reverse8
  import word_assembler_pkg::*;
(
  input  logic [LANE_W-1:0] in_byte,
  output logic [LANE_W-1:0] out_byte
);

  assign out_byte = rev8(in_byte);

endmodule

// File: rtl/word_assembler.sv
// Byte-serial to 32-bit word packer, receive-side inverse of the word splitter.
// The first accepted byte lands in lane 3 (bits 31:24), the fourth in lane 0.
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset
//   clear     : synchronous flush of the partial word and any held word
//   in_valid  : in_byte valid this cycle
//   in_byte   : serial input byte (bit-reversed when BIT_REV=1)
//   in_ready  : assembler accepts in_byte this cycle
//   out_word  : assembled word, stable while out_valid=1
//   out_valid : out_word holds a complete word
//   out_ready : consumer takes out_word this cycle
//   byte_cnt  : bytes collected toward the current word
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter bit BIT_REV = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [LANE_W-1:0] in_byte,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        byte_cnt
);

  localparam int PART_W = (WORD_LANES - 1) * LANE_W;

  state_t              state;
  logic [LANE_W-1:0]   lane_byte;
  logic [PART_W-1:0]   partial;
  logic                accept;
  logic                handoff;

  if (BIT_REV) begin : g_rev
    bit_reverse8 u_bit_reverse8 (
      .in_byte  (in_byte),
      .out_byte (lane_byte)
    );
  end else begin : g_pass
    assign lane_byte = in_byte;
  end

  // While a word is held, a byte may only enter in the same cycle the held
  // word leaves, which keeps one byte per cycle with no bubble.
  assign out_valid = (state == FULL);
  assign in_ready  = !clear && ((state == COLLECT) || out_ready);
  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      byte_cnt <= '0;
      out_word <= '0;
    end else if (clear) begin
      // out_word deliberately keeps its last value.
      state    <= COLLECT;
      byte_cnt <= '0;
    end else begin
      if (handoff) begin
        state <= COLLECT;
      end
      if (accept) begin
        if (byte_cnt == 2'd3) begin
          out_word <= {partial, lane_byte};
          state    <= FULL;
          byte_cnt <= '0;
        end else begin
          // Also covers an accept during handoff: byte_cnt is 0 in FULL,
          // so the new byte becomes lane 3 of the next word.
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

  // NOTE: the partial accumulator has no reset; every lane is rewritten
  // before byte_cnt can reach 3, so stale contents never reach out_word.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (byte_cnt)
        2'd0:    partial[PART_W-1 -: LANE_W]   <= lane_byte;
        2'd1:    partial[PART_W-9 -: LANE_W]   <= lane_byte;
        2'd2:    partial[LANE_W-1:0]           <= lane_byte;
        default: ;
      endcase
    end
  end

endmodule
